csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR storage and read-modify-write stage for the RV64 core. It sits directly upstream of the CSR read-data mux in the execute stage. It holds the implemented machine CSRs, applies CSRRW/CSRRS/CSRRC updates at the clock edge, and runs the mcycle/minstret counters. It returns the pre-update CSR value for the rd writeback and flags illegal accesses to the trap logic.

## Interface
- N, 64, data width of all CSRs and of src/rdata
- HARTID, 0, constant value returned by mhartid

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- valid  in  1  a CSR instruction is in execute this cycle
- op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
- addr  in  12  CSR address (instr[31:20])
- src  in  N  rs1 value, or zimm zero-extended to N for the immediate forms
- rs1_zero  in  1  rs1/zimm field is 0; RS/RC then do not write
- retire  in  1  one instruction retires this cycle
- rdata  out  N  current (pre-write) value of CSR at addr
- illegal  out  1  access at addr is illegal this cycle
- mie  out  1  mstatus.MIE, for the interrupt gate

## Operation
- Implemented CSRs (addr: behaviour, reset value):
  - 0x300 mstatus: writable bits MIE[3] and MPIE[7]; MPP[12:11] reads 11 and is not writable; all other bits read 0; reset 0x1800
  - 0x301 misa: read-only, 0x8000_0000_0000_0100 (MXL=2, I)
  - 0x340 mscratch: fully writable; reset 0
  - 0x341 mepc: writable; bits[1:0] always read 0; reset 0
  - 0xB00 mcycle, 0xB02 minstret: writable counters; reset 0
  - 0xC00 cycle, 0xC02 instret: read-only aliases of mcycle/minstret
  - 0xF11 mvendorid, 0xF12 marchid, 0xF13 mimpid: read-only 0; 0xF14 mhartid: read-only HARTID
- rdata: combinational, always the register value before this cycle's edge. Unimplemented addr reads 0.
- Write-intent: valid && op!=00 && (op==01 || !rs1_zero).
- illegal = valid && op!=00 && (addr unimplemented || (write-intent && addr[11:10]==2'b11)).
- Write occurs at the edge when write-intent && !illegal. New value: RW = src; RS = old | src; RC = old & ~src. The per-register write mask is then applied.
- An illegal access changes no state. An RS/RC with rs1_zero to a read-only CSR is legal and changes no state.
- mcycle: +1 every cycle out of reset. minstret: +1 when retire=1. Both wrap from 2^N-1 to 0 and are N bits wide.
- A CSR write to a counter in the same cycle as its increment: the written value wins; no increment is applied that cycle.
- mie output = mstatus[3], registered state (no combinational path from src).

## Timing
- Read latency 0 cycles: rdata and illegal are valid in the same cycle as addr/op.
- Write latency 1 edge: the value is visible on rdata from the cycle after the write.
- Back-to-back accesses to the same CSR: the second access reads the first access's result; no internal forwarding.
- Reset asserted at any time: all registers take their reset values immediately, including mid-instruction. rdata reflects reset values combinationally, illegal follows the inputs, and mie=0.
- First cycle after reset deassertion: mcycle reads 0, then increments at that edge.

## Test plan
- Reset then read: addr=0x300 -> rdata=0x1800, mie=0; addr=0x301 -> 0x8000_0000_0000_0100; addr=0xF14 with HARTID=3 -> 3.
- RMW sequence on mscratch: RW src=0xF0 -> RS src=0x0F -> RC src=0x3C. Next-cycle reads must be 0xF0, 0xFF, 0xC3; each op's rdata returns the prior value.
- mstatus masking: RW src=all-ones -> reads 0x1888, mie=1. Then RC src=0x8 -> reads 0x1880, mie=0.
- Illegal and no-op cases:
  - RW to 0xC00 -> illegal=1, mcycle keeps counting unaffected.
  - RS with rs1_zero to 0xC00 -> illegal=0, no change.
  - Access to 0x7C0 -> illegal=1, rdata=0.
- Counter collision and wrap:
  - RW mcycle src=0xFFFF_FFFF_FFFF_FFFF -> next read all-ones, following cycle 0.
  - RW minstret src=5 with retire=1 the same cycle -> reads 5, not 6.
- Async reset mid-stream: assert reset between clock edges after writing mepc=0x1003 (which reads 0x1000) -> mepc=0 and mcycle=0 immediately, before the next edge.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage with CSRRW/RS/RC read-modify-write and mcycle/minstret counters
module csr_file #(
    parameter int N = 64,
    parameter logic [N-1:0] HARTID = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic [1:0]   op,
    input  logic [11:0]  addr,
    input  logic [N-1:0] src,
    input  logic         rs1_zero,
    input  logic         retire,
    output logic [N-1:0] rdata,
    output logic         illegal,
    output logic         mie
);
    logic         st_mie, st_mpie;
    logic [N-1:0] mscratch, mepc, mcycle, minstret;
    logic [N-1:0] mstatus, misa, wdata;
    logic         impl, intent, wr;

    always_comb begin
        mstatus = '0;
        mstatus[12:11] = 2'b11;
        mstatus[7] = st_mpie;
        mstatus[3] = st_mie;
        misa = '0;
        misa[N-1] = 1'b1;
        misa[8] = 1'b1;
    end

    always_comb begin
        rdata = '0;
        impl = 1'b1;
        case (addr)
            12'h300: rdata = mstatus;
            12'h301: rdata = misa;
            12'h340: rdata = mscratch;
            12'h341: rdata = mepc;
            12'hB00, 12'hC00: rdata = mcycle;
            12'hB02, 12'hC02: rdata = minstret;
            12'hF11, 12'hF12, 12'hF13: rdata = '0;
            12'hF14: rdata = HARTID;
            default: impl = 1'b0;
        endcase
    end

    // RS/RC with a zero source is a pure read, so it is legal even on read-only CSRs
    assign intent  = valid && op != 2'b00 && (op == 2'b01 || !rs1_zero);
    assign illegal = valid && op != 2'b00 && (!impl || (intent && addr[11:10] == 2'b11));
    assign wr      = intent && !illegal;
    assign wdata   = op == 2'b01 ? src : op == 2'b10 ? (rdata | src) : (rdata & ~src);
    assign mie     = st_mie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            mscratch <= '0;
            mepc     <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr && addr == 12'h300) begin
                st_mie  <= wdata[3];
                st_mpie <= wdata[7];
            end
            if (wr && addr == 12'h340) mscratch <= wdata;
            if (wr && addr == 12'h341) mepc <= {wdata[N-1:2], 2'b00};
            mcycle   <= (wr && addr == 12'hB00) ? wdata : mcycle + N'(1);
            minstret <= (wr && addr == 12'hB02) ? wdata : minstret + N'(retire);
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed vectors with hand-computed expectations for csr_file
module tb_csr_file;
    logic        clk = 1'b0, reset, valid, rs1_zero, retire;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [63:0] src, rdata;
    logic        illegal, mie;
    int total = 0, bad = 0;

    csr_file #(.N(64), .HARTID(64'd3)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .addr(addr), .src(src),
        .rs1_zero(rs1_zero), .retire(retire), .rdata(rdata), .illegal(illegal), .mie(mie)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [1:0] o, input logic [11:0] a,
                       input logic [63:0] s, input logic z, input logic r);
        valid = v; op = o; addr = a; src = s; rs1_zero = z; retire = r;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 2'b00, 12'h300, 0, 0, 0);
        chk("rst_mstatus", rdata, 64'h1800);
        chk("rst_mie", {63'd0, mie}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        drv(0, 2'b00, 12'h301, 0, 0, 0);
        chk("rst_misa", rdata, 64'h8000_0000_0000_0100);
        drv(0, 2'b00, 12'hF14, 0, 0, 0);
        chk("rst_hartid", rdata, 64'd3);
        step();
        reset = 1'b0;
        drv(0, 2'b00, 12'hB00, 0, 0, 0);
        chk("mcycle_first", rdata, 64'd0);
        step();
        chk("mcycle_second", rdata, 64'd1);

        step(); drv(1, 2'b01, 12'h340, 64'hF0, 0, 0);
        chk("rw_old", rdata, 64'h0);
        step(); drv(1, 2'b10, 12'h340, 64'h0F, 0, 0);
        chk("rs_old", rdata, 64'hF0);
        step(); drv(1, 2'b11, 12'h340, 64'h3C, 0, 0);
        chk("rc_old", rdata, 64'hFF);
        step(); drv(0, 2'b00, 12'h340, 0, 0, 0);
        chk("rc_new", rdata, 64'hC3);

        step(); drv(1, 2'b01, 12'h300, '1, 0, 0);
        chk("mstatus_old", rdata, 64'h1800);
        chk("mie_not_comb", {63'd0, mie}, 64'd0);
        step(); drv(1, 2'b11, 12'h300, 64'h8, 0, 0);
        chk("mstatus_mask", rdata, 64'h1888);
        chk("mie_set", {63'd0, mie}, 64'd1);
        step(); drv(0, 2'b00, 12'h300, 0, 0, 0);
        chk("mstatus_rc", rdata, 64'h1880);
        chk("mie_clr", {63'd0, mie}, 64'd0);

        step(); drv(1, 2'b01, 12'hB00, 64'd100, 0, 0);
        step(); drv(0, 2'b00, 12'hC00, 0, 0, 0);
        chk("cycle_alias", rdata, 64'd100);
        chk("read_legal", {63'd0, illegal}, 64'd0);
        step(); drv(1, 2'b01, 12'hC00, 64'd0, 0, 0);
        chk("ro_rw_illegal", {63'd0, illegal}, 64'd1);
        chk("ro_rw_rdata", rdata, 64'd101);
        step(); drv(1, 2'b10, 12'hC00, 64'd0, 1, 0);
        chk("rs_zero_legal", {63'd0, illegal}, 64'd0);
        chk("cycle_unaffected", rdata, 64'd102);
        step(); drv(0, 2'b00, 12'hC00, 0, 0, 0);
        chk("cycle_after_rs0", rdata, 64'd103);
        step(); drv(1, 2'b01, 12'h7C0, 64'd5, 0, 0);
        chk("unimpl_illegal", {63'd0, illegal}, 64'd1);
        chk("unimpl_rdata", rdata, 64'd0);
        drv(1, 2'b01, 12'hF14, 64'd5, 0, 0);
        chk("hartid_rw_illegal", {63'd0, illegal}, 64'd1);
        drv(1, 2'b00, 12'h7C0, 64'd5, 0, 0);
        chk("op_none_legal", {63'd0, illegal}, 64'd0);

        step(); drv(1, 2'b01, 12'hB00, '1, 0, 0);
        step(); drv(0, 2'b00, 12'hB00, 0, 0, 0);
        chk("mcycle_ones", rdata, '1);
        step();
        chk("mcycle_wrap", rdata, 64'd0);

        step(); drv(1, 2'b01, 12'hB02, 64'd5, 0, 1);
        step(); drv(0, 2'b00, 12'hB02, 0, 0, 1);
        chk("minstret_write_wins", rdata, 64'd5);
        step(); drv(0, 2'b00, 12'hB02, 0, 0, 0);
        chk("minstret_retire", rdata, 64'd6);
        step();
        chk("minstret_hold", rdata, 64'd6);

        step(); drv(1, 2'b01, 12'h341, 64'h1003, 0, 0);
        step(); drv(0, 2'b00, 12'h341, 0, 0, 0);
        chk("mepc_align", rdata, 64'h1000);
        #2 reset = 1'b1;
        #1 chk("async_mepc", rdata, 64'd0);
        drv(0, 2'b00, 12'hB00, 0, 0, 0);
        chk("async_mcycle", rdata, 64'd0);
        drv(0, 2'b00, 12'h340, 0, 0, 0);
        chk("async_mscratch", rdata, 64'd0);
        drv(1, 2'b01, 12'hC02, 64'd1, 0, 0);
        chk("rst_illegal_follows", {63'd0, illegal}, 64'd1);
        reset = 1'b0;
        drv(0, 2'b00, 12'hB00, 0, 0, 0);
        chk("post_rst_mcycle0", rdata, 64'd0);
        step();
        chk("post_rst_mcycle1", rdata, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
